fbf_adder_driver: RTL and testbench
===================================

# fbf_adder_driver

Initiator-side sequencer for the SIZE×SIZE single-precision matrix adder's strobe/ready/ack interface. It collects operand matrices A and B as a word-serial stream, presents them on wide buses with `A_stb`/`B_stb`, and waits for `result_ready`. It then captures the wide result, acknowledges it with `result_ack`, and streams the result matrix out word-serially. It sits between a narrow 32-bit datapath and the matrix adder.

## Interface
- `SIZE`, default 4: matrix dimension; N = SIZE*SIZE words per matrix, counter width = clog2(N) (minimum 1).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  driver accepts a word this cycle.
- `in_data`  in  32  operand word (IEEE-754 single, passed through untouched).
- `A_stb`  out  1  operand A valid to adder.
- `B_stb`  out  1  operand B valid to adder.
- `A`  out  32*N  operand A; word k at bits [32k +: 32].
- `B`  out  32*N  operand B; same packing.
- `result_ready`  in  1  adder result valid.
- `result`  in  32*N  adder result; same packing.
- `result_ack`  out  1  result consumed.
- `out_valid`  out  1  result word valid downstream.
- `out_ready`  in  1  downstream accepts word.
- `out_data`  out  32  result word.
- `out_last`  out  1  high with final result word (k = N-1).
- `busy`  out  1  high in every state except LOAD_A with count 0.

## Operation
- States: LOAD_A, LOAD_B, ISSUE, ACK, DRAIN. Reset state: LOAD_A.
- LOAD_A: `in_ready`=1. Each transfer (`in_valid`&`in_ready` at edge) writes `in_data` to A word[count], count++. Transfer at count N-1 → count=0, LOAD_B.
- LOAD_B: same into B; transfer at count N-1 → ISSUE.
- ISSUE: `A_stb`=`B_stb`=1; A/B stable. On an edge with `result_ready`=1: capture `result` into internal result register → ACK. `result_ready` already high on the first ISSUE cycle is captured that cycle.
- ACK: `result_ack`=1, strobes 0. Stay until `result_ready` sampled 0 → DRAIN, count=0.
- DRAIN: `out_valid`=1, `out_data`=captured word[count], `out_last`=(count==N-1). Transfer (`out_valid`&`out_ready`) → count++. Transfer at N-1 → count=0, LOAD_A.
- `in_ready`=0 outside LOAD_A/LOAD_B; `in_valid` ignored there. `result_ready` is ignored outside ISSUE/ACK.
- A/B registers are not cleared between jobs. They are overwritten word by word on load.
- Reset (any state, any cycle): next state LOAD_A, counters 0, A/B/result registers all zero. In-flight data is discarded and no ack is issued.
- All outputs are decoded from registered state/counters. There is no combinational path from `in_valid`, `out_ready` or `result_ready` to any output.

## Timing
- Reset values: `in_ready`=1, `A_stb`=`B_stb`=0, `result_ack`=0, `out_valid`=0, `out_last`=0, `busy`=0, `A`=`B`=0, `out_data`=0.
- Load: minimum 2N cycles with `in_valid` held high. `A_stb` rises the cycle after the final B transfer.
- Capture to ack: `result_ack` is high starting the cycle after the capture edge. It is high for at least 1 cycle and stays high until the edge where `result_ready`=0 is sampled.
- `out_valid` rises the cycle after that edge. Drain takes a minimum of N cycles with `out_ready` held high.
- The first `in_ready` of the next job comes the cycle after the last output transfer.
- Back-pressure: `out_ready`=0 holds `out_data`/`out_last` stable indefinitely. Upstream gaps (`in_valid`=0) stall loading with no data loss.

## Test plan
- SIZE=4, stream 16×32'h3F800000 then 16×32'h40000000, adder model raises `result_ready` 5 cycles after `A_stb` with all words 32'h40400000 and drops it 1 cycle after `result_ack` → `A_stb` high exactly 5 cycles, `result_ack` high 2 cycles, 16 outputs of 32'h40400000, `out_last` only on the 16th.
- Load word k = k for A and 32'h100+k for B → `A[32k+:32]`==k and `B[32k+:32]`==32'h100+k while `A_stb` is high; model result = A word k → `out_data` sequence 0..15 in order.
- Random `in_valid` gaps and `out_ready` toggling at 50% → data identical to the no-stall run, `out_data` is stable whenever `out_valid`&!`out_ready`, and no extra or missing transfers.
- Model holds `result_ready`=1 continuously from time 0 → capture on the first ISSUE cycle. Nothing is captured during LOAD phases, and ACK persists until the model drops `result_ready`.
- Assert `reset` for 1 cycle mid-LOAD_B (word 7), mid-ISSUE and mid-DRAIN (word 9) → next cycle state is LOAD_A and all outputs are at reset values. A subsequent full job completes correctly.
- SIZE=2 build: N=4, full job with 8 input words → 4 output words, `out_last` on the 4th.

Source files
------------

// File: rtl/fbf_adder_driver.sv
// ----------------------------------------------------------------------------
// fbf_adder_driver
//
// Initiator-side sequencer for a SIZE x SIZE single-precision matrix adder
// that uses a strobe/ready/ack handshake. Operand matrices A and B arrive as
// a word-serial 32-bit stream. They are presented to the adder on wide buses
// with A_stb/B_stb. The wide result is captured when result_ready is seen,
// acknowledged with result_ack, and then streamed out word-serially.
//
// Handshake semantics (both streaming sides): a word moves on a rising clock
// edge where valid and ready are both high. The sender keeps data stable
// while valid is high and ready is low. Valid never depends on ready.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   in_valid      in   upstream word valid
//   in_ready      out  driver accepts a word (LOAD_A / LOAD_B)
//   in_data       in   32-bit operand word, passed through untouched
//   A_stb, B_stb  out  operands valid to the adder (ISSUE)
//   A, B          out  32*N operand buses, word k at [32k +: 32]
//   result_ready  in   adder result valid
//   result        in   32*N adder result, same packing
//   result_ack    out  result consumed (ACK)
//   out_valid     out  result word valid downstream (DRAIN)
//   out_ready     in   downstream accepts the word
//   out_data      out  32-bit result word
//   out_last      out  high with the final result word (k = N-1)
//   busy          out  low only when idle in LOAD_A with nothing loaded
//   dbg_state     out  current FSM state encoding
//                      (0 LOAD_A, 1 LOAD_B, 2 ISSUE, 3 ACK, 4 DRAIN)
//
// Every output is decoded from registered state, counter and data registers;
// there is no combinational path from in_valid, out_ready or result_ready
// to any output.
// ----------------------------------------------------------------------------
module fbf_adder_driver #(
    parameter int SIZE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     A_stb,
    output logic                     B_stb,
    output logic [32*SIZE*SIZE-1:0]  A,
    output logic [32*SIZE*SIZE-1:0]  B,
    input  logic                     result_ready,
    input  logic [32*SIZE*SIZE-1:0]  result,
    output logic                     result_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic [2:0]               dbg_state
);

    localparam int N  = SIZE * SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        ISSUE  = 3'd2,
        ACK    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [32*N-1:0] a_reg;
    logic [32*N-1:0] b_reg;
    logic [32*N-1:0] r_reg;

    logic in_fire;
    logic out_fire;
    logic at_last;

    // Handshake qualifiers; in_ready/out_valid are purely state decoded.
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign at_last  = (count == LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            LOAD_A: if (in_fire && at_last) state_next = LOAD_B;
            LOAD_B: if (in_fire && at_last) state_next = ISSUE;
            ISSUE:  if (result_ready)       state_next = ACK;
            ACK:    if (!result_ready)      state_next = DRAIN;
            DRAIN:  if (out_fire && at_last) state_next = LOAD_A;
            default:                        state_next = LOAD_A;
        endcase
    end

    // The single word counter is shared by both load phases and the drain.
    // It wraps to zero on the last word of each phase, so every phase
    // starts from word 0 without an explicit clear. Leaving ACK clears it
    // anyway so DRAIN always begins at word 0.
    always_comb begin
        count_next = count;
        if (in_fire || out_fire) begin
            count_next = at_last ? '0 : count + 1'b1;
        end
        if (state == ACK && !result_ready) begin
            count_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // State, counter and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_A;
            count <= '0;
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            // Operand registers are overwritten word by word, never cleared
            // between jobs.
            if (state == LOAD_A && in_fire) begin
                a_reg[32*count +: 32] <= in_data;
            end
            if (state == LOAD_B && in_fire) begin
                b_reg[32*count +: 32] <= in_data;
            end
            // A result that is already valid on the first ISSUE cycle is
            // taken on that cycle's edge.
            if (state == ISSUE && result_ready) begin
                r_reg <= result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state/counter only)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        A_stb      = 1'b0;
        B_stb      = 1'b0;
        result_ack = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        case (state)
            LOAD_A, LOAD_B: in_ready = 1'b1;
            ISSUE: begin
                A_stb = 1'b1;
                B_stb = 1'b1;
            end
            ACK:   result_ack = 1'b1;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = r_reg[32*count +: 32];
                out_last  = at_last;
            end
            default: ;
        endcase
    end

    assign A         = a_reg;
    assign B         = b_reg;
    assign busy      = !(state == LOAD_A && count == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_fbf_adder_driver.sv
// ----------------------------------------------------------------------------
// tb_fbf_adder_driver
//
// Directed bench for fbf_adder_driver (SIZE=4 main instance, SIZE=2 second
// instance). Inputs are driven and outputs sampled on the falling edge.
// A small adder model answers the strobe/ready/ack handshake, an output sink
// pops expected words from exp_q, and all checks go through check().
// ----------------------------------------------------------------------------
module tb_fbf_adder_driver;

  localparam int N = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- SIZE=4 DUT signals ----------------
  logic           in_valid, in_ready;
  logic [31:0]    in_data;
  logic           A_stb, B_stb;
  logic [32*N-1:0] A, B, result;
  logic           result_ready, result_ack;
  logic           out_valid, out_ready, out_last, busy;
  logic [31:0]    out_data;
  logic [2:0]     dbg_state;

  fbf_adder_driver #(.SIZE(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .A_stb(A_stb), .B_stb(B_stb), .A(A), .B(B),
    .result_ready(result_ready), .result(result), .result_ack(result_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- SIZE=2 DUT signals ----------------
  logic           s2_in_valid, s2_in_ready;
  logic [31:0]    s2_in_data;
  logic           s2_A_stb, s2_B_stb;
  logic [127:0]   s2_A, s2_B, s2_result;
  logic           s2_result_ready, s2_result_ack;
  logic           s2_out_valid, s2_out_ready, s2_out_last, s2_busy;
  logic [31:0]    s2_out_data;
  logic [2:0]     s2_dbg_state;

  fbf_adder_driver #(.SIZE(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_data(s2_in_data),
    .A_stb(s2_A_stb), .B_stb(s2_B_stb), .A(s2_A), .B(s2_B),
    .result_ready(s2_result_ready), .result(s2_result), .result_ack(s2_result_ack),
    .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_data(s2_out_data),
    .out_last(s2_out_last), .busy(s2_busy), .dbg_state(s2_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wa[N];
  logic [31:0] wb[N];
  logic [31:0] res_word   = 32'h0;
  bit          res_copy   = 1'b0;
  int          model_mode = 1;     // 0 silent, 1 delayed, 2 hold-high
  bit          stall_mode = 1'b0;
  int          sink_limit = N;
  int          k_out      = 0;
  int          done_cnt   = 0;
  int          stb_total  = 0;
  int          ack_total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- adder model ----------------
  // Delayed mode: result_ready rises so the strobes stay high 5 cycles and
  // drops once result_ack has been seen for 2 cycles. Hold mode: result_ready
  // is high except after result_ack has been seen for 4 cycles.
  int stb_cnt = 0;
  int ack_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      stb_cnt = A_stb ? stb_cnt + 1 : 0;
      ack_cnt = result_ack ? ack_cnt + 1 : 0;
      if (A_stb)      stb_total++;
      if (result_ack) ack_total++;
      result = res_copy ? A : {N{res_word}};
      case (model_mode)
        1: begin
          if (A_stb && stb_cnt == 5)               result_ready = 1'b1;
          else if (!A_stb && !result_ack)          result_ready = 1'b0;
          else if (result_ack && ack_cnt == 2)     result_ready = 1'b0;
        end
        2:       result_ready = !(result_ack && ack_cnt >= 4);
        default: result_ready = 1'b0;
      endcase
    end
  end

  // ---------------- output sink ----------------
  bit          prev_stall = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      out_ready = (k_out >= sink_limit) ? 1'b0 :
                  (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      if (out_valid && prev_stall) begin
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
        end
        check("out_last", out_last, (k_out == N - 1));
        if (k_out == N - 1) begin
          k_out = 0;
          done_cnt++;
        end else begin
          k_out++;
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid;
        held_data  = out_data;
        held_last  = out_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input bit gaps);
    int g;
    int t;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_words(input int na, input int nb, input bit gaps);
    for (int i = 0; i < na; i++) send_word(wa[i], gaps);
    for (int i = 0; i < nb; i++) send_word(wb[i], gaps);
  endtask

  task automatic wait_stb();
    int t = 0;
    while (!A_stb && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stb_seen", A_stb, 1);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("job_done", (done_cnt >= target), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"},    dbg_state, 3'd0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_stb"},      {A_stb, B_stb}, 2'b00);
    check({tag, "_ack"},      result_ack, 0);
    check({tag, "_ovalid"},   out_valid, 0);
    check({tag, "_olast"},    out_last, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_odata"},    out_data, 0);
    check({tag, "_AB_zero"},  (A == '0) && (B == '0), 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full job: load, check operand buses while strobed, drain, check counts.
  task automatic run_job(input bit gaps, input bit stall, input bit copy,
                         input int exp_stb, input int exp_ack);
    int target;
    for (int i = 0; i < N; i++) exp_q.push_back(copy ? wa[i] : res_word);
    res_copy   = copy;
    stall_mode = stall;
    stb_total  = 0;
    ack_total  = 0;
    target     = done_cnt + 1;
    load_words(N, N, gaps);
    wait_stb();
    for (int i = 0; i < N; i++) begin
      check("A_word", A[32*i +: 32], wa[i]);
      check("B_word", B[32*i +: 32], wb[i]);
    end
    check("B_stb", B_stb, 1);
    wait_done(target);
    @(negedge clk);
    check("stb_cycles", stb_total, exp_stb);
    check("ack_cycles", ack_total, exp_ack);
    check("exp_q_empty", exp_q.size(), 0);
    check("next_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    stall_mode = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0;
    result_ready = 1'b0; result = '0; out_ready = 1'b0;
    s2_in_valid = 1'b0; s2_in_data = '0; s2_result_ready = 1'b0;
    s2_result = '0; s2_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst0");

    // Job 1: 1.0 + 2.0 with a constant 3.0 result, delayed adder.
    for (int i = 0; i < N; i++) begin
      wa[i] = 32'h3F80_0000;
      wb[i] = 32'h4000_0000;
    end
    res_word = 32'h4040_0000;
    model_mode = 1;
    run_job(1'b0, 1'b0, 1'b0, 5, 2);

    // Job 2: indexed operands, result = A, no stalls.
    for (int i = 0; i < N; i++) begin
      wa[i] = 32'(i);
      wb[i] = 32'h100 + 32'(i);
    end
    run_job(1'b0, 1'b0, 1'b1, 5, 2);

    // Job 3: same data with input gaps and output back-pressure.
    run_job(1'b1, 1'b1, 1'b1, 5, 2);

    // Job 4: result_ready held high; capture on first ISSUE cycle.
    res_word = 32'h40A0_0000;
    model_mode = 2;
    run_job(1'b0, 1'b0, 1'b0, 1, 4);
    model_mode = 1;
    @(negedge clk);

    // Reset mid-LOAD_B after 7 B words.
    load_words(N, 7, 1'b0);
    check("midB_state", dbg_state, 3'd1);
    pulse_reset();
    check_reset_state("rstB");

    // Reset mid-ISSUE with a silent adder.
    model_mode = 0;
    load_words(N, N, 1'b0);
    wait_stb();
    repeat (2) @(negedge clk);
    check("midI_state", dbg_state, 3'd2);
    pulse_reset();
    check_reset_state("rstI");
    model_mode = 1;

    // Reset mid-DRAIN after 9 output words.
    for (int i = 0; i < N; i++) exp_q.push_back(wa[i]);
    res_copy = 1'b1;
    sink_limit = 9;
    load_words(N, N, 1'b0);
    t = 0;
    while (k_out < 9 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("midD_words", k_out, 9);
    check("midD_state", dbg_state, 3'd4);
    pulse_reset();
    check_reset_state("rstD");
    exp_q.delete();
    k_out = 0;
    sink_limit = N;

    // Full job after the resets.
    for (int i = 0; i < N; i++) begin
      wa[i] = 32'h3F80_0000;
      wb[i] = 32'h4000_0000;
    end
    res_word = 32'h4040_0000;
    run_job(1'b0, 1'b0, 1'b0, 5, 2);

    // SIZE=2 instance: 8 input words, 4 output words.
    for (int i = 0; i < 8; i++) begin
      s2_in_valid = 1'b1;
      s2_in_data  = (i < 4) ? 32'h10 + 32'(i) : 32'h20 + 32'(i - 4);
      @(negedge clk);
    end
    s2_in_valid = 1'b0;
    check("s2_stb", {s2_A_stb, s2_B_stb}, 2'b11);
    check("s2_A", s2_A[63:0],  64'h0000_0011_0000_0010);
    check("s2_A_hi", s2_A[127:64], 64'h0000_0013_0000_0012);
    check("s2_B", s2_B[127:64], 64'h0000_0023_0000_0022);
    s2_result = {32'h33, 32'h32, 32'h31, 32'h30};
    s2_result_ready = 1'b1;
    @(negedge clk);
    check("s2_ack", s2_result_ack, 1);
    s2_result_ready = 1'b0;
    @(negedge clk);
    s2_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s2_ovalid", s2_out_valid, 1);
      check("s2_odata", s2_out_data, 32'h30 + 32'(i));
      check("s2_olast", s2_out_last, (i == 3));
      @(negedge clk);
    end
    check("s2_in_ready", s2_in_ready, 1);
    check("s2_idle", s2_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
